// File: rtl/main_mem_arbiter_pkg.sv
// Shared types and encodings for the MainMem port arbiter.
package main_mem_arbiter_pkg;

  // Access type encoding, same values as the CPU-to-MainMem link
  localparam logic DIAT_READ  = 1'b0;
  localparam logic DIAT_WRITE = 1'b1;

  // Access size encoding, same values as the MainMem size field
  localparam logic [1:0] SZ_8  = 2'd0;
  localparam logic [1:0] SZ_16 = 2'd1;
  localparam logic [1:0] SZ_32 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } st_arb_t;

  // Command latched from the granted requester and presented to MainMem
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        typ;
    logic [1:0]  size;
  } mem_cmd_t;

endpackage

// File: rtl/main_mem_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request scanning upward from last_grant+1.
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IW-1:0]      o_idx
);

  int   w_k;
  logic w_found;

  // Scan NUM_REQ positions starting just after the last winner; first hit wins
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_k      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_k = (int'(i_last) + i) % NUM_REQ;
      if (!w_found && i_req[w_k]) begin
        w_found       = 1'b1;
        o_onehot[w_k] = 1'b1;
        o_idx         = IW'(w_k);
      end
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing the single MainMem port between NUM_REQ
// requesters, one transaction in flight, with a WAIT timeout so a hung
// memory cannot lock up the requesters.
module main_mem_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0][31:0] wdata_i,
  input  logic [NUM_REQ-1:0]       acc_type_i,
  input  logic [NUM_REQ-1:0][1:0]  acc_size_i,
  output logic [NUM_REQ-1:0]       wait_o,
  output logic [NUM_REQ-1:0][31:0] rdata_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  output logic                     mem_type_o,
  output logic [1:0]               mem_size_o,
  input  logic                     mem_wait_i,
  input  logic [31:0]              mem_rdata_i
);
  import main_mem_arbiter_pkg::*;

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_MAX = '1;

  st_arb_t                   r_state;
  mem_cmd_t                  r_cmd;
  logic                      r_mem_req;
  logic [IW-1:0]             r_grant;
  logic [IW-1:0]             r_last;
  logic [CW-1:0]             r_cnt;
  logic [NUM_REQ-1:0]        r_wait;
  logic [NUM_REQ-1:0]        r_err;
  logic [NUM_REQ-1:0][31:0]  r_rdata;

  logic [NUM_REQ-1:0]        w_onehot;
  logic [IW-1:0]             w_idx;
  logic                      w_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .i_req    (req_i),
    .i_last   (r_last),
    .o_onehot (w_onehot),
    .o_idx    (w_idx)
  );

  assign w_any = |w_onehot;

  assign wait_o      = r_wait;
  assign err_o       = r_err;
  assign rdata_o     = r_rdata;
  assign mem_req_o   = r_mem_req;
  assign mem_addr_o  = r_cmd.addr;
  assign mem_wdata_o = r_cmd.wdata;
  assign mem_type_o  = r_cmd.typ;
  assign mem_size_o  = r_cmd.size;

  // Arbiter FSM; completion pulses and the request strobe are one-cycle
  // registered outputs that default back to idle values every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cmd     <= '0;
      r_mem_req <= 1'b0;
      r_grant   <= '0;
      r_last    <= IW'(NUM_REQ - 1);
      r_cnt     <= '0;
      r_wait    <= '1;
      r_err     <= '0;
      r_rdata   <= '0;
    end else begin
      r_mem_req <= 1'b0;
      r_wait    <= '1;
      r_err     <= '0;
      r_rdata   <= '0;
      case (r_state)
        // Grant only once MainMem is quiet: covers leftovers from a reset
        // mid-transaction as well as normal operation.
        ST_IDLE: begin
          if (w_any && !mem_wait_i) begin
            r_grant    <= w_idx;
            r_cmd.addr  <= addr_i[w_idx];
            r_cmd.wdata <= wdata_i[w_idx];
            r_cmd.typ   <= acc_type_i[w_idx];
            r_cmd.size  <= acc_size_i[w_idx];
            r_mem_req  <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!mem_wait_i) begin
            r_wait[r_grant]  <= 1'b0;
            r_rdata[r_grant] <= (r_cmd.typ == DIAT_READ) ? mem_rdata_i : 32'h0;
            r_state          <= ST_DONE;
          end else begin
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CW'(1);
            // Abort to the requester now; MainMem is drained separately
            if (TIMEOUT_CYCLES != 0 && int'(r_cnt) == TO_LAST) begin
              r_wait[r_grant] <= 1'b0;
              r_err[r_grant]  <= 1'b1;
              r_last          <= r_grant;
              r_state         <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!mem_wait_i) r_state <= ST_IDLE;
        end
        ST_DONE: begin
          r_last  <= r_grant;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter: a table of single transactions plus
// hand-written sequences for alternation, timeout, reset and late requests.
module tb_main_mem_arbiter;
  import main_mem_arbiter_pkg::*;

  logic             gclk = 1'b0;
  logic             grst_n = 1'b0;
  logic [1:0]       req_i = '0;
  logic [1:0][31:0] addr_i = '0;
  logic [1:0][31:0] wdata_i = '0;
  logic [1:0]       acc_type_i = '0;
  logic [1:0][1:0]  acc_size_i = '0;
  logic [1:0]       wait_o;
  logic [1:0][31:0] rdata_o;
  logic [1:0]       err_o;
  logic             mem_req_o;
  logic [31:0]      mem_addr_o, mem_wdata_o;
  logic             mem_type_o;
  logic [1:0]       mem_size_o;
  logic             mem_wait_i;
  logic [31:0]      mem_rdata_i;

  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  int          busy = 0;
  logic [31:0] mrd = '0;

  always #5 gclk = ~gclk;

  main_mem_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(gclk), .rst_n(grst_n), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .acc_type_i(acc_type_i), .acc_size_i(acc_size_i), .wait_o(wait_o), .rdata_o(rdata_o),
    .err_o(err_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_type_o(mem_type_o), .mem_size_o(mem_size_o), .mem_wait_i(mem_wait_i),
    .mem_rdata_i(mem_rdata_i)
  );

  // MainMem model: busy for 'lat' cycles after the strobe; not reset by grst_n
  always @(posedge gclk) begin
    if (mem_req_o) busy <= lat;
    else if (busy != 0) busy <= busy - 1;
  end
  assign mem_wait_i  = (busy != 0);
  assign mem_rdata_i = mrd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge gclk);
    @(negedge gclk);
  endtask

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        typ;
    logic [1:0]  size;
    int          lat;
    logic [31:0] mrd;
    int          exp_cmpl;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        vt[6];
  int          nreq, treq, tcmp, oth, ncmp, pend, viol, t2, t1;
  logic [31:0] g_addr, g_wdata, g_rd;
  logic        g_typ, g_err;
  logic [1:0]  g_size;
  int          ct[4], cid[4];

  initial begin
    vt[0] = '{0, 32'h0000_0100, 32'h0,         DIAT_READ,  SZ_32, 0, 32'hDEAD_BEEF, 3,  32'hDEAD_BEEF, 1'b0};
    vt[1] = '{1, 32'h0000_0000, 32'h1234_5678, DIAT_WRITE, SZ_32, 0, 32'hFFFF_FFFF, 3,  32'h0,         1'b0};
    vt[2] = '{0, 32'h0000_0003, 32'h0,         DIAT_READ,  SZ_8,  2, 32'h0000_00A5, 5,  32'h0000_00A5, 1'b0};
    vt[3] = '{1, 32'hFFFF_FFFE, 32'h0,         DIAT_READ,  SZ_16, 5, 32'h0000_1234, 8,  32'h0000_1234, 1'b0};
    vt[4] = '{0, 32'h0000_0040, 32'h0,         DIAT_READ,  SZ_32, 7, 32'h5555_AAAA, 10, 32'h5555_AAAA, 1'b0};
    vt[5] = '{1, 32'h0000_0080, 32'h0,         DIAT_READ,  SZ_32, 8, 32'h7777_7777, 10, 32'h0,         1'b1};

    // Reset state
    step(); step();
    chk("rst_wait", 32'(wait_o), 32'h3);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_rdata", rdata_o[0] | rdata_o[1], 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_mem_fields", mem_addr_o | mem_wdata_o | 32'(mem_type_o) | 32'(mem_size_o), 32'h0);
    grst_n = 1'b1;
    repeat (3) step();

    // Table of single transactions
    for (int v = 0; v < 6; v++) begin
      req_i[vt[v].id]      = 1'b1;
      addr_i[vt[v].id]     = vt[v].addr;
      wdata_i[vt[v].id]    = vt[v].wdata;
      acc_type_i[vt[v].id] = vt[v].typ;
      acc_size_i[vt[v].id] = vt[v].size;
      lat = vt[v].lat;
      mrd = vt[v].mrd;
      nreq = 0; treq = -1; tcmp = -1; oth = 0;
      g_addr = '0; g_wdata = '0; g_typ = 1'b0; g_size = '0; g_rd = '0; g_err = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        step();
        if (mem_req_o) begin
          nreq++;
          if (treq < 0) begin
            treq = k; g_addr = mem_addr_o; g_wdata = mem_wdata_o;
            g_typ = mem_type_o; g_size = mem_size_o;
          end
        end
        if (!wait_o[vt[v].id] && tcmp < 0) begin
          tcmp = k; g_rd = rdata_o[vt[v].id]; g_err = err_o[vt[v].id];
          req_i[vt[v].id] = 1'b0;
        end
        if (!wait_o[1 - vt[v].id]) oth++;
      end
      chk($sformatf("v%0d_req_t", v), 32'(treq), 32'd1);
      chk($sformatf("v%0d_req_n", v), 32'(nreq), 32'd1);
      chk($sformatf("v%0d_addr", v), g_addr, vt[v].addr);
      chk($sformatf("v%0d_wdata", v), g_wdata, vt[v].wdata);
      chk($sformatf("v%0d_type", v), 32'(g_typ), 32'(vt[v].typ));
      chk($sformatf("v%0d_size", v), 32'(g_size), 32'(vt[v].size));
      chk($sformatf("v%0d_cmpl_t", v), 32'(tcmp), 32'(vt[v].exp_cmpl));
      chk($sformatf("v%0d_rdata", v), g_rd, vt[v].exp_rd);
      chk($sformatf("v%0d_err", v), 32'(g_err), 32'(vt[v].exp_err));
      chk($sformatf("v%0d_other_wait", v), 32'(oth), 32'd0);
    end

    // Both requesters held, 3-cycle memory: alternate 0,1,0,1, 6 cycles apart
    req_i = 2'b11; addr_i[0] = 32'h1000; addr_i[1] = 32'h2000; acc_type_i = '0;
    lat = 2; mrd = 32'h0BAD_F00D;
    ncmp = 0; pend = 0; viol = 0;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (mem_req_o) begin
        if (pend != 0) viol++;
        pend = 1;
      end
      for (int id = 0; id < 2; id++)
        if (!wait_o[id]) begin
          if (ncmp < 4) begin ct[ncmp] = k; cid[ncmp] = id; end
          ncmp++; pend = 0;
        end
      if (ncmp >= 4) req_i = 2'b00;
    end
    req_i = 2'b00;
    chk("alt_count", 32'(ncmp), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alt%0d_id", i), 32'(cid[i]), 32'(i % 2));
      chk($sformatf("alt%0d_t", i), 32'(ct[i]), 32'(5 + 6 * i));
    end
    chk("alt_overlap", 32'(viol), 32'd0);
    lat = 0;
    repeat (4) step();

    // req 1 rises in the completion cycle of req 0
    req_i[0] = 1'b1; addr_i[0] = 32'h40; addr_i[1] = 32'h80; lat = 0;
    t1 = -1; t2 = -1; tcmp = -1; nreq = 0; g_addr = '0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (mem_req_o) begin
        nreq++;
        if (nreq == 2) begin t2 = k; g_addr = mem_addr_o; end
      end
      if (!wait_o[1] && tcmp < 0) begin tcmp = k; req_i[1] = 1'b0; end
      if (!wait_o[0] && t1 < 0) begin t1 = k; req_i[0] = 1'b0; req_i[1] = 1'b1; end
    end
    req_i = 2'b00;
    chk("late_cmpl0_t", 32'(t1), 32'd3);
    chk("late_req_t", 32'(t2), 32'd5);
    chk("late_req_addr", g_addr, 32'h80);
    chk("late_cmpl1_t", 32'(tcmp), 32'd7);
    repeat (4) step();

    // Timeout: memory busy 20 cycles, both requesting
    req_i = 2'b11; addr_i[0] = 32'h200; addr_i[1] = 32'h300; lat = 20;
    t1 = -1; tcmp = -1; t2 = -1; nreq = 0; g_err = 1'b0; g_rd = '1; g_addr = '0; oth = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 2) lat = 0;
      if (mem_req_o) begin
        nreq++;
        if (nreq == 2) begin t2 = k; g_addr = mem_addr_o; end
      end
      if (!wait_o[0] && t1 < 0) begin
        t1 = k; g_err = err_o[0]; g_rd = rdata_o[0]; req_i[0] = 1'b0;
      end
      if (!wait_o[1] && tcmp < 0) begin tcmp = k; oth = 32'(err_o[1]); req_i[1] = 1'b0; end
    end
    req_i = 2'b00;
    chk("to_cmpl0_t", 32'(t1), 32'd10);
    chk("to_err0", 32'(g_err), 32'd1);
    chk("to_rdata0", g_rd, 32'h0);
    chk("to_req_n", 32'(nreq), 32'd2);
    chk("to_req1_t", 32'(t2), 32'd24);
    chk("to_req1_addr", g_addr, 32'h300);
    chk("to_cmpl1_t", 32'(tcmp), 32'd26);
    chk("to_err1", 32'(oth), 32'd0);
    repeat (4) step();

    // Reset during WAIT while MainMem stays busy
    req_i[0] = 1'b1; addr_i[0] = 32'h500; wdata_i[0] = 32'hCAFE_F00D;
    acc_type_i[0] = DIAT_WRITE; acc_size_i[0] = SZ_16; lat = 30;
    t2 = -1; tcmp = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 2) lat = 0;
      if (k == 5) begin
        grst_n = 1'b0;
        #1;
        chk("mid_rst_wait", 32'(wait_o), 32'h3);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_mem_req", 32'(mem_req_o), 32'h0);
        chk("mid_rst_mem_fields", mem_addr_o | mem_wdata_o | 32'(mem_type_o) | 32'(mem_size_o), 32'h0);
      end
      if (k == 6) grst_n = 1'b1;
      if (k > 6 && mem_req_o && t2 < 0) t2 = k;
      if (k > 6 && !wait_o[0] && tcmp < 0) begin tcmp = k; g_rd = rdata_o[0]; req_i[0] = 1'b0; end
    end
    req_i = 2'b00;
    chk("rst_reissue_t", 32'(t2), 32'd33);
    chk("rst_cmpl_t", 32'(tcmp), 32'd35);
    chk("rst_cmpl_rdata", g_rd, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
